// File: rtl/arty7_gpio_debounce_if.sv
// ---------------------------------------------------------------------------
// arty7_gpio_debounce_if
//   Bundles the pin-side and SoC-side signals of the GPIO debounce stage.
//
//   gpio_i    : raw asynchronous board pins (switches/buttons)
//   gpio_o    : debounced stable level per pin
//   rise_o    : sticky rising-edge flags
//   fall_o    : sticky falling-edge flags
//   evt_clr_i : per-pin clear of the rise/fall flags
//
//   master : the side that drives pins/clears and reads results (board top)
//   slave  : the debounce stage itself
// ---------------------------------------------------------------------------
interface arty7_gpio_debounce_if #(
  parameter int NUM_PINS = 4
);
  logic [NUM_PINS-1:0] gpio_i;
  logic [NUM_PINS-1:0] gpio_o;
  logic [NUM_PINS-1:0] rise_o;
  logic [NUM_PINS-1:0] fall_o;
  logic [NUM_PINS-1:0] evt_clr_i;

  modport master (
    output gpio_i,
    output evt_clr_i,
    input  gpio_o,
    input  rise_o,
    input  fall_o
  );

  modport slave (
    input  gpio_i,
    input  evt_clr_i,
    output gpio_o,
    output rise_o,
    output fall_o
  );
endinterface

// File: rtl/arty7_gpio_debounce.sv
// ---------------------------------------------------------------------------
// arty7_gpio_debounce
//   Input conditioning between the Arty A7 switch/button pins and the SoC
//   GPIO input bus. Each pin is synchronised with two flops, then a new level
//   must persist for DBNC_CYCLES consecutive cycles before it is accepted as
//   the stable level. Optional sticky rise/fall event flags with a clear.
//
// Ports:
//   clk_i   : system clock (clock-wizard output)
//   rst_i   : synchronous, active-high reset
//   bus     : arty7_gpio_debounce_if.slave
//               gpio_i    raw pins in
//               gpio_o    debounced levels out (registered)
//               rise_o    sticky rising-edge flags
//               fall_o    sticky falling-edge flags
//               evt_clr_i per-pin flag clear
//
// Parameters:
//   NUM_PINS    : number of conditioned pins
//   DBNC_CYCLES : cycles a new level must hold before acceptance (>= 1)
//   RESET_VAL   : reset value of synchroniser flops and gpio_o
//
// Build option:
//   GPIO_DBNC_EDGE_EN : when defined, builds the sticky edge flags and their
//                       clear logic; otherwise rise_o/fall_o are tied to 0
//                       and evt_clr_i is ignored.
// ---------------------------------------------------------------------------
module arty7_gpio_debounce #(
  parameter int                  NUM_PINS    = 4,
  parameter int                  DBNC_CYCLES = 500000,
  parameter logic [NUM_PINS-1:0] RESET_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  arty7_gpio_debounce_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DBNC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic [NUM_PINS-1:0] s1;
  logic [NUM_PINS-1:0] s2;
  logic [NUM_PINS-1:0] stable;
  logic [NUM_PINS-1:0] accept;
  logic [CNT_W-1:0]    cnt [NUM_PINS];

  // Two-flop synchroniser; the reset value is applied here too so that a
  // freshly reset pin does not look like a pending change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= bus.gpio_i;
      s2 <= s1;
    end
  end

  // A pin's new level is accepted on the edge where it has already been seen
  // DBNC_CYCLES-1 times in a row and is still different from the stable one.
  always_comb begin
    accept = '0;
    for (int k = 0; k < NUM_PINS; k++) begin
      accept[k] = (s2[k] != stable[k]) && (cnt[k] == CNT_LAST);
    end
  end

  // Counter only advances while the synchronised level differs from the
  // stable one, and is cleared on acceptance, so it never passes CNT_LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable <= RESET_VAL;
      for (int k = 0; k < NUM_PINS; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PINS; k++) begin
        if (accept[k]) begin
          stable[k] <= s2[k];
          cnt[k]    <= '0;
        end else if (s2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.gpio_o = stable;

`ifdef GPIO_DBNC_EDGE_EN
  logic [NUM_PINS-1:0] rise_q;
  logic [NUM_PINS-1:0] fall_q;

  // Set has priority over clear so an event landing on a clear edge is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= (accept &  s2) | (rise_q & ~bus.evt_clr_i);
      fall_q <= (accept & ~s2) | (fall_q & ~bus.evt_clr_i);
    end
  end

  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;
`else
  logic [NUM_PINS-1:0] unused_evt_clr;

  assign unused_evt_clr = bus.evt_clr_i;
  assign bus.rise_o     = '0;
  assign bus.fall_o     = '0;
`endif

endmodule
